serial_demux8: RTL and testbench
================================

SERIAL_DEMUX8 -- requirements
Module: serial_demux8

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0; 0 routes slot k to Q[k], 1 routes slot k to Q[7-k].
REQ-002 SHALL have port Clock, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port D, input, 1 bit; serial data bit.
REQ-005 SHALL have port En, input, 1 bit; sample strobe, so D is captured on a rising edge where En=1.
REQ-006 SHALL have port Abort, input, 1 bit; discards the partial frame and returns to slot 0.
REQ-007 SHALL have port Q, output, 8 bits; last completed word.
REQ-008 SHALL have port S, output, 4 bits; current slot index, the slot the next sample fills.
REQ-009 SHALL have port Valid, output, 1 bit; one-cycle pulse, high in the cycle after a frame completes.
REQ-010 SHALL have port Busy, output, 1 bit; 1 when S != 0, meaning a frame is partially filled.
REQ-011 SHALL have port ParErr, output, 1 bit; parity error flag, qualified by Valid.

Function
REQ-012 SHALL act as a clocked 1-to-N demultiplexer: the slot counter S selects which staging bit receives D.
REQ-013 On an edge with En=1 and Abort=0, staging[S] SHALL take D and S SHALL increment.
REQ-014 Sample S=LAST with En=1 SHALL wrap S to 0, load Q from staging plus the final bit, and assert Valid, all on that same edge.
REQ-015 Latency from the final sample edge to Q/Valid SHALL be 0 cycles; both are visible in the following cycle.
REQ-016 Valid SHALL deassert on the next edge unless another frame completes on it.
REQ-017 Back-to-back frames (En held high) SHALL produce a Valid pulse every N cycles with no dead cycle.
REQ-018 En=0 SHALL hold S and staging unchanged; gaps between samples are unlimited.
REQ-019 Q SHALL hold its value between completions; a partial frame SHALL never alter Q.
REQ-020 Abort=1 SHALL set S=0 and suppress Valid, with priority over En; Q SHALL be unchanged.
REQ-021 Abort and a final-slot En in the same cycle SHALL resolve to Abort: no Valid, Q unchanged.
REQ-022 Without the parity feature, N=8, LAST=7, S[3]=0 always, and ParErr=0 always.

Reset
REQ-023 Reset=1 at an edge SHALL force S=0, Q=8'h00, Valid=0, ParErr=0, Busy=0 and clear staging.
REQ-024 Reset SHALL have priority over Abort and En.
REQ-025 Reset mid-frame SHALL discard the partial frame, with no Valid pulse.

Configuration
REQ-026 Macro SERIAL_DEMUX8_PARITY_EN SHALL select the parity feature.
REQ-027 When SERIAL_DEMUX8_PARITY_EN is defined:
- N=9, LAST=8.
- Slot 8 carries an even-parity bit over the 8 data bits.
- On completion, Q SHALL load the data regardless of parity.
- ParErr SHALL equal (XOR of data bits) XOR (parity bit), valid only in the Valid cycle, and 0 otherwise.
REQ-028 When SERIAL_DEMUX8_PARITY_EN is undefined, REQ-022 SHALL apply, with no parity logic synthesized.

Structure
REQ-029 Package serial_demux8_pkg SHALL hold:
- DATA_W=8 and SLOT_W=4.
- NUM_SLOTS, which is 8, or 9 under the macro.
REQ-030 Sub-module slot_counter SHALL implement the 4-bit slot counter:
- inputs: Clock, Reset, Inc, Clr;
- outputs: Count, Wrap.
REQ-031 The data routing SHALL be a decoder of S into a per-bit load enable of staging.

Verification
REQ-032 Reset, then 8 samples with En=1 and D=1,0,1,1,0,0,1,0, MSB_FIRST=0 -> Q=8'h4D and a single Valid pulse in cycle 9; S returns to 0.
REQ-033 Same bits with MSB_FIRST=1 -> Q=8'hB2.
REQ-034 5 samples, then Abort=1, then 8 samples of 8'hFF -> no Valid after the first 5 samples; Q=8'hFF only after the second frame; Busy=0 after Abort.
REQ-035 En toggled 1,0,1,0 across 16 cycles for 8 samples of 8'hA5 -> Q=8'hA5; Valid occurs exactly once; S is stable during En=0.
REQ-036 Reset asserted at slot 6 -> S=0, Q=8'h00, no Valid; the next full frame of 8'h3C yields Q=8'h3C.
REQ-037 With SERIAL_DEMUX8_PARITY_EN, data 8'h4D with parity 0 -> ParErr=0; the same data with parity 1 -> Q=8'h4D, ParErr=1 with Valid.

Source files
------------

// File: rtl/serial_demux8_pkg.sv
// Shared widths and frame geometry for the serial_demux8 slice.
// Frame length grows to 9 slots when SERIAL_DEMUX8_PARITY_EN is defined.
package serial_demux8_pkg;

  localparam int DATA_W = 8;
  localparam int SLOT_W = 4;

`ifdef SERIAL_DEMUX8_PARITY_EN
  localparam int NUM_SLOTS = 9;
`else
  localparam int NUM_SLOTS = 8;
`endif

  localparam int LAST_SLOT = NUM_SLOTS - 1;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[DATA_W-1-i] = x[i];
    return r;
  endfunction

endpackage

// File: rtl/serial_demux8_slot_counter.sv
// Slot counter for serial_demux8: counts accepted samples and flags the
// sample that completes a frame (Wrap) on the same cycle it is presented.
module slot_counter
  import serial_demux8_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Inc,
  input  logic              Clr,
  output logic [SLOT_W-1:0] Count,
  output logic              Wrap
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(LAST_SLOT);

  // Clr (abort) beats Inc, so an aborted final sample never wraps.
  assign Wrap = Inc && !Clr && (Count == LAST);

  always_ff @(posedge Clock) begin
    // NOTE: Reset is synchronous, so it is tested inside the clocked block and kept out of the sensitivity list.
    if (Reset) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc) begin
      // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
      Count <= Wrap ? '0 : Count + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/serial_demux8.sv
// Clocked 1-to-N serial demultiplexer: each strobed bit lands in the staging
// slot selected by S; the final slot loads Q and pulses Valid.
// Optional even-parity slot selected by SERIAL_DEMUX8_PARITY_EN.
module serial_demux8
  import serial_demux8_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              D,
  input  logic              En,
  input  logic              Abort,
  output logic [DATA_W-1:0] Q,
  output logic [SLOT_W-1:0] S,
  output logic              Valid,
  output logic              Busy,
  output logic              ParErr
);

  // The final slot is never staged: it is taken straight from D on the wrap edge.
  localparam int STAGE_W = NUM_SLOTS - 1;

  logic                 sample;
  logic                 wrap;
  logic [STAGE_W-1:0]   load_en;
  logic [STAGE_W-1:0]   staging;
  logic [NUM_SLOTS-1:0] frame;
  logic [DATA_W-1:0]    data_word;
  logic [DATA_W-1:0]    q_next;

  assign sample = En && !Abort;

  slot_counter u_slot_counter (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (En),
    .Clr   (Abort),
    .Count (S),
    .Wrap  (wrap)
  );

  assign Busy = (S != '0);

  always_comb begin
    load_en = '0;
    for (int i = 0; i < STAGE_W; i++) begin
      load_en[i] = sample && (S == SLOT_W'(i));
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: the staging array is cleared on reset so no bits from before reset are ever observable.
    if (Reset) begin
      staging <= '0;
    end else begin
      for (int i = 0; i < STAGE_W; i++) begin
        if (load_en[i]) staging[i] <= D;
      end
    end
  end

  assign frame     = {D, staging};
  assign data_word = frame[DATA_W-1:0];
  assign q_next    = (MSB_FIRST != 0) ? bit_reverse(data_word) : data_word;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q     <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= wrap;
      if (wrap) Q <= q_next;
    end
  end

`ifdef SERIAL_DEMUX8_PARITY_EN
  // XOR over data plus parity slot is 1 exactly when even parity is violated.
  always_ff @(posedge Clock) begin
    if (Reset) ParErr <= 1'b0;
    else       ParErr <= wrap && (^frame);
  end
`else
  assign ParErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_demux8.sv
// Self-checking bench for serial_demux8: directed scenarios then random traffic,
// compared each cycle against a queue-based frame model (both bit orders).
module tb_serial_demux8;
  import serial_demux8_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Reset = 1'b1;
  logic D = 1'b0;
  logic En = 1'b0;
  logic Abort = 1'b0;

  logic [7:0] q0, q1;
  logic [3:0] s0, s1;
  logic       v0, v1, b0, b1, p0, p1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         bits_q[$];
  logic [7:0] exp_q0 = 8'h00;
  logic [7:0] exp_q1 = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_perr = 1'b0;

`ifdef SERIAL_DEMUX8_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  serial_demux8 #(.MSB_FIRST(0)) dut_lsb (
    .Clock(Clock), .Reset(Reset), .D(D), .En(En), .Abort(Abort),
    .Q(q0), .S(s0), .Valid(v0), .Busy(b0), .ParErr(p0)
  );

  serial_demux8 #(.MSB_FIRST(1)) dut_msb (
    .Clock(Clock), .Reset(Reset), .D(D), .En(En), .Abort(Abort),
    .Q(q1), .S(s1), .Valid(v1), .Busy(b1), .ParErr(p1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic d, input logic en, input logic ab, input logic rst);
    logic [7:0] w;
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    if (rst) begin
      bits_q.delete();
      exp_q0 = 8'h00;
      exp_q1 = 8'h00;
    end else if (ab) begin
      bits_q.delete();
    end else if (en) begin
      bits_q.push_back(d);
      if (bits_q.size() == N) begin
        w = 8'h00;
        for (int k = 0; k < 8; k++) begin
          w[k] = bits_q[k];
          exp_q1[7-k] = bits_q[k];
        end
        exp_q0 = w;
        exp_valid = 1'b1;
`ifdef SERIAL_DEMUX8_PARITY_EN
        exp_perr = (^w) ^ bits_q[8];
`endif
        bits_q.delete();
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] es;
    es = 4'(bits_q.size());
    check("q_lsb",   32'(q0), 32'(exp_q0));
    check("q_msb",   32'(q1), 32'(exp_q1));
    check("s_lsb",   32'(s0), 32'(es));
    check("s_msb",   32'(s1), 32'(es));
    check("valid",   32'(v0), 32'(exp_valid));
    check("valid_m", 32'(v1), 32'(exp_valid));
    check("busy",    32'(b0), 32'(es != 4'd0));
    check("parerr",  32'(p0), 32'(exp_perr));
  endtask

  task automatic step(input logic d, input logic en, input logic ab, input logic rst);
    D = d; En = en; Abort = ab; Reset = rst;
    @(posedge Clock);
    model_update(d, en, ab, rst);
    #1;
    compare_all();
    @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par);
    for (int k = 0; k < N; k++) step((k < 8) ? data[k] : par, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    logic [3:0] s_hold;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_q", 32'(q0), 32'h00);
    check("reset_s", 32'(s0), 32'h0);

    // Bits 1,0,1,1,0,0,1,0 -> 4D (LSB slot order) / B2 (reversed)
    send_frame(8'h4D, 1'b0);
    check("frame_4d_q",     32'(q0), 32'h4D);
    check("frame_4d_q_msb", 32'(q1), 32'hB2);
    check("frame_4d_valid", 32'(v0), 32'h1);
    check("frame_4d_s",     32'(s0), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("valid_one_cycle", 32'(v0), 32'h0);

    // Partial frame, abort, then a full frame of FF
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_busy", 32'(b0), 32'h0);
    check("abort_q",    32'(q0), 32'h4D);
    send_frame(8'hFF, 1'b0);
    check("frame_ff_q", 32'(q0), 32'hFF);

    // En alternating 1,0 over 16 cycles for A5; S must hold in idle cycles
    a5 = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      step(a5[k], 1'b1, 1'b0, 1'b0);
      s_hold = s0;
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      check("gap_s_hold", 32'(s0), 32'(s_hold));
    end
`ifdef SERIAL_DEMUX8_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    check("frame_a5_q", 32'(q0), 32'hA5);

    // Reset at slot 6, then a full 3C frame
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset_s", 32'(s0), 32'h6);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("midreset_q", 32'(q0), 32'h00);
    check("midreset_s", 32'(s0), 32'h0);
    check("midreset_v", 32'(v0), 32'h0);
    send_frame(8'h3C, 1'b0);
    check("frame_3c_q", 32'(q0), 32'h3C);

    // Abort coincident with the final-slot sample wins
    for (int k = 0; k < N - 1; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("abort_last_v", 32'(v0), 32'h0);
    check("abort_last_q", 32'(q0), 32'h3C);

`ifdef SERIAL_DEMUX8_PARITY_EN
    send_frame(8'h4D, 1'b0);
    check("par_ok_err", 32'(p0), 32'h0);
    send_frame(8'h4D, 1'b1);
    check("par_bad_q",   32'(q0), 32'h4D);
    check("par_bad_err", 32'(p0), 32'h1);
    check("par_bad_v",   32'(v0), 32'h1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r_en, r_ab, r_rst;
      r_en  = $urandom_range(0, 99);
      r_ab  = $urandom_range(0, 99);
      r_rst = $urandom_range(0, 199);
      step(1'($urandom_range(0, 1)), r_en < 75, r_ab < 3, r_rst < 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
